// File: rtl/stg1if_queue_if.sv
// rtl/stg1if_queue_if.sv - fetch-to-decode instruction queue signal bundle
interface stg1if_queue_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // fetch side
   logic [ADDR_W-1:0] iw_pc;
   logic [DATA_W-1:0] iw_mem_data;
   logic              iw_ia_valid;
   logic              ow_ia_ready;
   logic              iw_flush;
   // decode side
   logic [ADDR_W-1:0] ow_pc;
   logic [DATA_W-1:0] ow_instr;
   logic              ow_valid;
   logic              iw_ready;
   // status
   logic [CNT_W-1:0]  ow_count;
   logic              ow_ovf;

   // master: the environment driving fetch words and decode consumption
   modport master (
      output iw_pc, iw_mem_data, iw_ia_valid, iw_flush, iw_ready,
      input  ow_ia_ready, ow_pc, ow_instr, ow_valid, ow_count, ow_ovf
   );

   // slave: the queue itself
   modport slave (
      input  iw_pc, iw_mem_data, iw_ia_valid, iw_flush, iw_ready,
      output ow_ia_ready, ow_pc, ow_instr, ow_valid, ow_count, ow_ovf
   );
endinterface

// File: rtl/stg1if_queue.sv
// rtl/stg1if_queue.sv - fetch-stage {pc, instr} queue feeding decode
module stg1if_queue #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 24,
   parameter int DEPTH  = 4
) (
   input  logic          iw_clk,
   input  logic          iw_rst,
   stg1if_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];

   logic             full;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] head;

   // Handshake qualification; flush suppresses both sides, and a full
   // queue refuses a word even when decode pops in the same cycle.
   always_comb begin
      full      = (count_q == FULL_CNT);
      not_empty = (count_q != '0);
      push      = q.iw_ia_valid & ~full & ~q.iw_flush;
      pop       = not_empty & q.iw_ready & ~q.iw_flush;
   end

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (q.iw_ia_valid & full & ~q.iw_flush);
      if (q.iw_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage write: only the tail entry changes, and only on an accepted push.
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {q.iw_pc, q.iw_mem_data};
   end

   // Control state; reset clears everything immediately, including ovf.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage carries no reset; stale words are masked by the count.
   always_ff @(posedge iw_clk) begin
      mem_q <= mem_d;
   end

   // Outputs come only from registered state; an empty queue presents a
   // zero pc/instr bubble to decode.
   always_comb begin
      head          = mem_q[rd_ptr_q];
      q.ow_ia_ready = ~full;
      q.ow_valid    = not_empty;
      q.ow_count    = count_q;
      q.ow_ovf      = ovf_q;
      q.ow_pc       = '0;
      q.ow_instr    = '0;
      if (not_empty) begin
         q.ow_pc    = head[ENT_W-1:DATA_W];
         q.ow_instr = head[DATA_W-1:0];
      end
   end
endmodule

// File: tb/tb_stg1if_queue.sv
// tb/tb_stg1if_queue.sv - self-checking bench for stg1if_queue
module tb_stg1if_queue;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 24;
   localparam int DEPTH  = 4;
   localparam int NV     = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stg1if_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) qif ();

   stg1if_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .iw_clk (clk),
      .iw_rst (rst),
      .q      (qif.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        valid;
      logic [23:0] pc;
      logic        ready;
      logic        flush;
      logic [2:0]  cnt;
      logic [23:0] epc;
      logic        eia;
      logic        eovf;
   } vec_t;

   vec_t vt [NV];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // instruction word offered for a pc is always pc + 0x90 (0x10 -> 0xA0)
   task automatic drive(input logic v, input logic [23:0] pc, input logic r, input logic f);
      qif.iw_ia_valid = v;
      qif.iw_pc       = pc;
      qif.iw_mem_data = v ? pc + 24'h90 : 24'h0;
      qif.iw_ready    = r;
      qif.iw_flush    = f;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [2:0] cnt, input logic [23:0] epc,
                               input logic eia, input logic eovf);
      logic [23:0] einstr;
      einstr = (cnt != 3'd0) ? epc + 24'h90 : 24'h0;
      check({tag, ".count"}, 32'(qif.ow_count), 32'(cnt));
      check({tag, ".valid"}, 32'(qif.ow_valid), 32'(cnt != 3'd0));
      check({tag, ".pc"}, 32'(qif.ow_pc), 32'(epc));
      check({tag, ".instr"}, 32'(qif.ow_instr), 32'(einstr));
      check({tag, ".ia_ready"}, 32'(qif.ow_ia_ready), 32'(eia));
      check({tag, ".ovf"}, 32'(qif.ow_ovf), 32'(eovf));
   endtask

   initial begin
      //          valid  pc      ready  flush  cnt   epc     ia     ovf
      // fill to full, then a refused fifth offer
      vt[0]  = '{1'b1, 24'h10, 1'b0, 1'b0, 3'd1, 24'h10, 1'b1, 1'b0};
      vt[1]  = '{1'b1, 24'h11, 1'b0, 1'b0, 3'd2, 24'h10, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 24'h12, 1'b0, 1'b0, 3'd3, 24'h10, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 24'h13, 1'b0, 1'b0, 3'd4, 24'h10, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 24'h14, 1'b0, 1'b0, 3'd4, 24'h10, 1'b0, 1'b1};
      // drain from full while offering 0x14..0x17; the first offer is refused
      vt[5]  = '{1'b1, 24'h14, 1'b1, 1'b0, 3'd3, 24'h11, 1'b1, 1'b1};
      vt[6]  = '{1'b1, 24'h14, 1'b1, 1'b0, 3'd3, 24'h12, 1'b1, 1'b1};
      vt[7]  = '{1'b1, 24'h15, 1'b1, 1'b0, 3'd3, 24'h13, 1'b1, 1'b1};
      vt[8]  = '{1'b1, 24'h16, 1'b1, 1'b0, 3'd3, 24'h14, 1'b1, 1'b1};
      vt[9]  = '{1'b1, 24'h17, 1'b1, 1'b0, 3'd3, 24'h15, 1'b1, 1'b1};
      vt[10] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd2, 24'h16, 1'b1, 1'b1};
      vt[11] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd1, 24'h17, 1'b1, 1'b1};
      vt[12] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd0, 24'h00, 1'b1, 1'b1};
      // simultaneous push/pop at count 2
      vt[13] = '{1'b1, 24'h30, 1'b0, 1'b0, 3'd1, 24'h30, 1'b1, 1'b1};
      vt[14] = '{1'b1, 24'h31, 1'b0, 1'b0, 3'd2, 24'h30, 1'b1, 1'b1};
      vt[15] = '{1'b1, 24'h32, 1'b1, 1'b0, 3'd2, 24'h31, 1'b1, 1'b1};
      vt[16] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd1, 24'h32, 1'b1, 1'b1};
      vt[17] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd0, 24'h00, 1'b1, 1'b1};
      // flush at count 3 with push and pop requested
      vt[18] = '{1'b1, 24'h40, 1'b0, 1'b0, 3'd1, 24'h40, 1'b1, 1'b1};
      vt[19] = '{1'b1, 24'h41, 1'b0, 1'b0, 3'd2, 24'h40, 1'b1, 1'b1};
      vt[20] = '{1'b1, 24'h42, 1'b0, 1'b0, 3'd3, 24'h40, 1'b1, 1'b1};
      vt[21] = '{1'b1, 24'h43, 1'b1, 1'b1, 3'd0, 24'h00, 1'b1, 1'b1};
      vt[22] = '{1'b0, 24'h00, 1'b0, 1'b0, 3'd0, 24'h00, 1'b1, 1'b1};
      vt[23] = '{1'b1, 24'h44, 1'b0, 1'b0, 3'd1, 24'h44, 1'b1, 1'b1};
      vt[24] = '{1'b0, 24'h00, 1'b1, 1'b0, 3'd0, 24'h00, 1'b1, 1'b1};

      drive(1'b0, 24'h0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expect_state("reset", 3'd0, 24'h0, 1'b1, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].valid, vt[i].pc, vt[i].ready, vt[i].flush);
         step();
         expect_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].epc, vt[i].eia, vt[i].eovf);
      end

      // streaming: push and pop every cycle, head trails the offered pc by one edge
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 24'h20 + 24'(k), 1'b1, 1'b0);
         step();
         expect_state($sformatf("stream%0d", k), 3'd1, 24'h20 + 24'(k), 1'b1, 1'b1);
      end
      drive(1'b0, 24'h0, 1'b1, 1'b0);
      step();
      expect_state("stream_end", 3'd0, 24'h0, 1'b1, 1'b1);

      // reset asserted between edges with three words queued
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 24'h50 + 24'(k), 1'b0, 1'b0);
         step();
         expect_state($sformatf("pre_rst%0d", k), 3'(k + 1), 24'h50, 1'b1, 1'b1);
      end
      drive(1'b0, 24'h0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      expect_state("midrun_rst", 3'd0, 24'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 24'h60, 1'b0, 1'b0);
      step();
      expect_state("post_rst", 3'd1, 24'h60, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
